bit_stream_serializer: RTL and testbench

//  Parallel-to-serial front end for the 1101 sequence detector: accepts WIDTH-bit

---
 rtl/bit_stream_serializer.sv | 154 +++++++++++++++
 tb/tb_bit_stream_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_serializer.sv
// Double-buffered parallel-to-serial front end: WIDTH-bit words in, MSB-first bits out.
// Define SER_PARITY_EN to append an even-parity bit after each word's LSB.
module bit_stream_serializer #(
    parameter int   WIDTH    = 8,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy,
    output logic [1:0]       fsm_state_o
);

`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             word_done_q, word_done_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             load;
    logic             take;

    // Handshake: a word transfers on any rising edge where in_valid=1 and in_ready=1;
    // in_ready is a register equal to "holding register empty", so it never depends on in_valid.
    assign take = in_valid & in_ready_q;

`ifdef SER_PARITY_EN
    logic par_q, par_d;
    assign par_d = load ? ^hold_q : par_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        bit_out_d   = IDLE_BIT;
        bit_valid_d = 1'b0;
        word_done_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: load = hold_full_q;
            S_SHIFT: begin
                // cnt_q is the index of the bit currently on bit_out
                if (cnt_q != LAST_IDX) begin
                    cnt_d       = cnt_q + 1'b1;
                    bit_valid_d = 1'b1;
                    bit_out_d   = shift_q[WIDTH-1];
                    shift_d     = {shift_q[WIDTH-2:0], 1'b0};
`ifdef SER_PARITY_EN
                    if (cnt_d == CW'(WIDTH)) bit_out_d = par_q;
`endif
                    word_done_d = (cnt_d == LAST_IDX);
                end else if (GAP == 0) begin
                    load = hold_full_q;
                    if (!hold_full_q) state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (int'(gap_q) + 1 >= GAP) begin
                    load = hold_full_q;
                    if (!hold_full_q) state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reload puts the MSB on the wire at this edge, so the stream has no bubble.
        if (load) begin
            state_d     = S_SHIFT;
            cnt_d       = '0;
            bit_valid_d = 1'b1;
            bit_out_d   = hold_q[WIDTH-1];
            shift_d     = {hold_q[WIDTH-2:0], 1'b0};
        end

        hold_full_d = (hold_full_q & ~load) | take;
        hold_d      = take ? in_data : hold_q;
        in_ready_d  = ~hold_full_d;
        busy_d      = (state_d != S_IDLE) | hold_full_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            bit_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            word_done_q <= word_done_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign word_done   = word_done_q;
    assign busy        = busy_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: instance 0 (GAP=0, IDLE_BIT=0), instance 1 (GAP=2, IDLE_BIT=1).
module tb_bit_stream_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data0, in_data1;
  logic       in_valid0, in_valid1;
  logic       in_ready0, in_ready1;
  logic       bit_out0, bit_out1;
  logic       bit_valid0, bit_valid1;
  logic       word_done0, word_done1;
  logic       busy0, busy1;
  logic [1:0] fsm_state0, fsm_state1;

  int n_checks = 0;
  int n_fail   = 0;
  logic       rec = 1'b0;
  logic [4:0] tr0[$];
  logic [4:0] tr1[$];
  logic [7:0] tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'hC3};

  localparam int F_READY = 4;
  localparam int F_BUSY  = 3;
  localparam int F_VALID = 2;
  localparam int F_BIT   = 1;
  localparam int F_DONE  = 0;

  bit_stream_serializer #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .bit_out(bit_out0), .bit_valid(bit_valid0),
    .word_done(word_done0), .busy(busy0), .fsm_state_o(fsm_state0)
  );

  bit_stream_serializer #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .bit_out(bit_out1), .bit_valid(bit_valid1),
    .word_done(word_done1), .busy(busy1), .fsm_state_o(fsm_state1)
  );

  // clock / trace sampling (1 time unit after each rising edge)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rec) begin
      tr0.push_back({in_ready0, busy0, bit_valid0, bit_out0, word_done0});
      tr1.push_back({in_ready1, busy1, bit_valid1, bit_out1, word_done1});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // first trace entry lands in the MSB of the result
  function automatic logic [31:0] field_bits(input int inst, input int pos, input int len);
    logic [31:0] r;
    logic [4:0]  e;
    r = '0;
    for (int i = 0; i < len; i++) begin
      e = (inst == 0) ? tr0[i] : tr1[i];
      r = {r[30:0], e[pos]};
    end
    return r;
  endfunction

  function automatic int count_1101(input int len);
    logic [3:0] sh;
    int         c;
    sh = '0;
    c  = 0;
    for (int i = 0; i < len; i++) begin
      if (tr0[i][F_VALID]) begin
        sh = {sh[2:0], tr0[i][F_BIT]};
        if (sh == 4'b1101) c++;
      end
    end
    return c;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic send_word(input int inst, input logic [7:0] w);
    int n;
    n = 0;
    if (inst == 0) begin in_data0 = w; in_valid0 = 1'b1; end
    else           begin in_data1 = w; in_valid1 = 1'b1; end
    while (((inst == 0) ? in_ready0 : in_ready1) == 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("send_timeout", 32'(n), 32'(0));
    @(negedge clk);
    if (inst == 0) in_valid0 = 1'b0;
    else           in_valid1 = 1'b0;
  endtask

  task automatic start_trace();
    tr0.delete();
    tr1.delete();
    rec = 1'b1;
  endtask

  task automatic stop_trace(input int cycles);
    repeat (cycles) @(negedge clk);
    rec = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_data0  = '0;
    in_data1  = '0;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_ready0", in_ready0, 1'b1);
    check_eq("rst_busy0",  busy0, 1'b0);
    check_eq("rst_valid0", bit_valid0, 1'b0);
    check_eq("rst_done0",  word_done0, 1'b0);
    check_eq("rst_bit0",   bit_out0, 1'b0);
    check_eq("rst_state0", fsm_state0, 2'd0);
    check_eq("rst_ready1", in_ready1, 1'b1);
    check_eq("rst_bit1",   bit_out1, 1'b1);
    check_eq("rst_valid1", bit_valid1, 1'b0);
    check_eq("rst_busy1",  busy1, 1'b0);

`ifdef SER_PARITY_EN
    // 8'h07 plus its even-parity bit
    start_trace();
    send_word(0, 8'h07);
    stop_trace(14);
    check_eq("t6_len",   32'(tr0.size() >= 11), 1);
    check_eq("t6_valid", field_bits(0, F_VALID, 11), 11'b0_111111111_0);
    check_eq("t6_bits",  field_bits(0, F_BIT,   11), 11'b0_000001111_0);
    check_eq("t6_done",  field_bits(0, F_DONE,  11), 11'b0_000000001_0);
`else
    // single word 8'hD0
    start_trace();
    send_word(0, 8'hD0);
    stop_trace(12);
    check_eq("t1_len",   32'(tr0.size() >= 10), 1);
    check_eq("t1_valid", field_bits(0, F_VALID, 10), 10'b0111111110);
    check_eq("t1_bits",  field_bits(0, F_BIT,   10), 10'b0110100000);
    check_eq("t1_done",  field_bits(0, F_DONE,  10), 10'b0000000010);
    check_eq("t1_ready", field_bits(0, F_READY, 10), 10'b0111111111);
    check_eq("t1_busy",  field_bits(0, F_BUSY,  10), 10'b1111111110);
    check_eq("t1_detect", 32'(count_1101(10)), 1);

    // back-to-back 8'hA5, 8'h3C
    start_trace();
    send_word(0, 8'hA5);
    send_word(0, 8'h3C);
    stop_trace(18);
    check_eq("t2_len",   32'(tr0.size() >= 18), 1);
    check_eq("t2_valid", field_bits(0, F_VALID, 18), 18'b0_1111111111111111_0);
    check_eq("t2_bits",  field_bits(0, F_BIT,   18), 18'b0_1010010100111100_0);
    check_eq("t2_done",  field_bits(0, F_DONE,  18), 18'b0_0000000100000001_0);
    check_eq("t2_ready", field_bits(0, F_READY, 18), 18'b01_0000000_111111111);
    check_eq("t2_busy",  field_bits(0, F_BUSY,  18), 18'b111111111111111110);

    // GAP=2 instance: 8'hC5 then 8'h3A, idle slots drive 1
    start_trace();
    send_word(1, 8'hC5);
    send_word(1, 8'h3A);
    stop_trace(22);
    check_eq("t3_len",   32'(tr1.size() >= 21), 1);
    check_eq("t3_valid", field_bits(1, F_VALID, 21), 21'b0_11111111_00_11111111_00);
    check_eq("t3_bits",  field_bits(1, F_BIT,   21), 21'b1_11000101_11_00111010_11);
    check_eq("t3_done",  field_bits(1, F_DONE,  21), 21'b0_00000001_00_00000001_00);
    check_eq("t3_ready", field_bits(1, F_READY, 21), 21'b0_1_000000000_1111111111);
    check_eq("t3_busy",  field_bits(1, F_BUSY,  21), 21'h1FFFFF);
    repeat (4) @(negedge clk);
    check_eq("t3_idle_state", fsm_state1, 2'd0);

    // hold full while in_data changes every cycle; only tbl[7] is presented at the ready edge
    start_trace();
    send_word(0, 8'h55);
    send_word(0, 8'h11);
    for (int i = 0; i < 8; i++) begin
      in_data0  = tbl[i];
      in_valid0 = 1'b1;
      if (i == 6) check_eq("t5_ready_low",  in_ready0, 1'b0);
      if (i == 7) check_eq("t5_ready_high", in_ready0, 1'b1);
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    stop_trace(20);
    check_eq("t5_len",   32'(tr0.size() >= 26), 1);
    check_eq("t5_valid", field_bits(0, F_VALID, 26), 26'b0_111111111111111111111111_0);
    check_eq("t5_bits",  field_bits(0, F_BIT,   26), 26'b0_010101010001000111000011_0);
    check_eq("t5_done",  field_bits(0, F_DONE,  26), 26'b0_000000010000000100000001_0);
    check_eq("t5_ready", field_bits(0, F_READY, 26), 26'b0_1_0000000_1_0000000_111111111);

    // reset pulse after 3 bits of 8'hF0, then 8'h81
    send_word(0, 8'hF0);
    repeat (3) @(negedge clk);
    check_eq("t4_pre_valid", bit_valid0, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("t4_valid", bit_valid0, 1'b0);
    check_eq("t4_bit",   bit_out0, 1'b0);
    check_eq("t4_ready", in_ready0, 1'b1);
    check_eq("t4_busy",  busy0, 1'b0);
    check_eq("t4_state", fsm_state0, 2'd0);
    check_eq("t4_bit1",  bit_out1, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_trace();
    send_word(0, 8'h81);
    stop_trace(12);
    check_eq("t4_len",    32'(tr0.size() >= 10), 1);
    check_eq("t4_valid2", field_bits(0, F_VALID, 10), 10'b0111111110);
    check_eq("t4_bits2",  field_bits(0, F_BIT,   10), 10'b0100000010);
    check_eq("t4_done2",  field_bits(0, F_DONE,  10), 10'b0000000010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
